game_sequencer: RTL
===================

Name: game_sequencer

Overview:
- Central game controller for the VGA runner game.
- Sequences the player-motion and obstacle-motion datapaths once per video frame, and runs the game state machine (idle / play / hit / game over).
- Keeps the score (0..99) and the difficulty level.
- Sits between the PicoBlaze port bits, vga_sync vsync, the collision detector and the cmove/volver motion counters, replacing the free-running movx controllers.

Parameters:
- JUMP_FRAMES, 20, maximum frames the player rises before forced fall.
- HIT_FRAMES, 60, frames spent in HIT (flash) before GAME_OVER.
- LEVEL_STEP, 5, obstacle wraps per level increment.
- MAX_LEVEL, 3, saturation value of level (obstacle moves level+1 px/frame).
- SCORE_MAX, 99, score saturation value (two-digit display).

Ports:
- CLK_50M  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  start button level; already synchronous.
- jump  in  1  jump request level (PicoBlaze portA[0]).
- vsync  in  1  vga_sync vsync (active-low pulse).
- collide  in  1  collision flag, level.
- obs_wrap  in  1  obstacle reached its left limit, level.
- ply_floor  in  1  player at floor limit (cmove x_min).
- ply_apex  in  1  player at apex limit (cmove x_max).
- ply_step  out  1  one-cycle move strobe to player counter.
- ply_up  out  1  direction for ply_step (1 = up); valid only when ply_step=1.
- obs_step  out  1  one-cycle move strobe to obstacle counter.
- obs_load  out  1  one-cycle pulse reloading the obstacle to its start position.
- score  out  7  binary score 0..99, feeds tobcd.
- level  out  2  current difficulty 0..MAX_LEVEL.
- playing  out  1  high in PLAY.
- flash  out  1  toggles every 8 frames in HIT; 0 otherwise.
- game_over  out  1  high in GAME_OVER.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, jump sub-FSM GROUND.
  - All outputs 0; internal counters 0.
- frame_tick: vsync registered once; tick = previous 1 and current 0. One-cycle pulse, one cycle after the falling edge is sampled.
- Edge detect: start and jump are registered; rise = previous 0 and current 1. Levels held high give one event only.
- Main FSM:
  - IDLE: start rise -> PLAY. Same cycle: score=0, level=0, wrap counter=0, obs_load=1.
  - PLAY: collide=1 on any cycle -> HIT. Collision has priority over obs_wrap in the same cycle; no score increment then.
  - HIT: no step strobes issued. Frame counter counts ticks; at HIT_FRAMES ticks -> GAME_OVER.
  - GAME_OVER: start rise -> PLAY, with the same clearing as from IDLE.
- Jump sub-FSM (advances only in PLAY; forced to GROUND outside PLAY):
  - GROUND: jump rise -> RISE, frame count=0. Jump while RISE/FALL is ignored, not queued.
  - RISE: on each tick, ply_step=1 and ply_up=1 (registered, cycle after tick). Go to FALL when ply_apex=1, or when the count reaches JUMP_FRAMES-1 at a tick.
  - FALL: on each tick, ply_step=1 and ply_up=0. Go to GROUND when ply_floor=1 at a tick; no step is issued that frame.
- Obstacle:
  - In PLAY, each tick starts a burst: obs_step=1 for level+1 consecutive cycles, beginning the cycle after the tick.
  - A burst in progress completes even if the state leaves PLAY.
- Scoring:
  - obs_wrap rising edge in PLAY: score+1, saturating at SCORE_MAX; wrap counter+1; obs_load=1 next cycle.
  - When the wrap counter reaches LEVEL_STEP: counter=0, level+1, saturating at MAX_LEVEL.
- Outputs registered; no combinational path from inputs to outputs.

Optional Feature:
- GAME_SEQ_PAUSE_EN.
- Defined: adds input port pause (level) and state PAUSE.
  - PLAY + pause rise -> PAUSE; PAUSE + pause rise -> PLAY.
  - In PAUSE: no strobes, collide ignored, score/level/jump-FSM frozen, playing=0.
- Undefined: port and state absent; behaviour as above.

Decomposition:
- Package game_pkg:
  - state enum (IDLE, PLAY, HIT, GAME_OVER, PAUSE);
  - jump enum (GROUND, RISE, FALL);
  - constant SCORE_W=7.
- One sub-module: game_jump_fsm. Inputs: clock, reset, enable, tick, jump_rise, ply_floor, ply_apex. Outputs: ply_step, ply_up.
- Edge/tick detection stays inline.

Test Plan:
- Reset then start rise -> PLAY, score=0, obs_load pulse 1 cycle; 3 vsync falls at level 0 -> exactly 3 single-cycle obs_step.
- jump rise at ground, ply_apex never set -> 20 ticks of ply_step & ply_up=1, then ply_up=0 until ply_floor; second jump rise mid-air -> no effect.
- 5 obs_wrap events -> score=5, level=1; next tick gives 2-cycle obs_step burst; 20 wraps -> level saturates at 3 (4-cycle bursts).
- collide and obs_wrap in the same cycle -> HIT, score unchanged; after 60 ticks game_over=1; start rise -> PLAY, score=0.
- 104 wraps -> score holds 99.
- rst_n low mid-jump in PLAY -> all outputs 0 immediately (async), IDLE after release.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the runner-game sequencer.
package game_pkg;

  localparam int SCORE_W = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    HIT       = 3'd2,
    GAME_OVER = 3'd3,
    PAUSE     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_t;

endpackage

// File: rtl/game_jump_fsm.sv
// Player jump controller: ground / rise / fall, one move strobe per frame tick.
module game_jump_fsm
  import game_pkg::*;
#(
  parameter int JUMP_FRAMES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic tick,
  input  logic jump_rise,
  input  logic ply_floor,
  input  logic ply_apex,
  output logic ply_step,
  output logic ply_up
);

  localparam int CW = (JUMP_FRAMES > 1) ? $clog2(JUMP_FRAMES) : 1;

  jump_t          js;
  logic [CW-1:0]  cnt;

  // Reaching the apex ends the rise without a further upward step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      js       <= GROUND;
      cnt      <= '0;
      ply_step <= 1'b0;
      ply_up   <= 1'b0;
    end else begin
      ply_step <= 1'b0;
      ply_up   <= 1'b0;
      if (!enable) begin
        js  <= GROUND;
        cnt <= '0;
      end else begin
        case (js)
          GROUND: begin
            if (jump_rise) begin
              js  <= RISE;
              cnt <= '0;
            end
          end
          RISE: begin
            if (tick) begin
              if (ply_apex) begin
                js <= FALL;
              end else begin
                ply_step <= 1'b1;
                ply_up   <= 1'b1;
                if (cnt == CW'(JUMP_FRAMES - 1)) js <= FALL;
                else cnt <= cnt + CW'(1);
              end
            end
          end
          FALL: begin
            if (tick) begin
              if (ply_floor) js <= GROUND;
              else ply_step <= 1'b1;
            end
          end
          default: js <= GROUND;
        endcase
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Runner-game controller: frame sequencing, game FSM, score and level.
// Optional pause input/state enabled by defining GAME_SEQ_PAUSE_EN.
module game_sequencer
  import game_pkg::*;
#(
  parameter int JUMP_FRAMES = 20,
  parameter int HIT_FRAMES  = 60,
  parameter int LEVEL_STEP  = 5,
  parameter int MAX_LEVEL   = 3,
  parameter int SCORE_MAX   = 99
) (
  input  logic               CLK_50M,
  input  logic               rst_n,
`ifdef GAME_SEQ_PAUSE_EN
  input  logic               pause,
`endif
  input  logic               start,
  input  logic               jump,
  input  logic               vsync,
  input  logic               collide,
  input  logic               obs_wrap,
  input  logic               ply_floor,
  input  logic               ply_apex,
  output logic               ply_step,
  output logic               ply_up,
  output logic               obs_step,
  output logic               obs_load,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         level,
  output logic               playing,
  output logic               flash,
  output logic               game_over
);

  localparam int HW = $clog2(HIT_FRAMES + 1);
  localparam int WW = $clog2(LEVEL_STEP + 1);

  state_t         state, state_nxt;
  logic           vsync_q, tick;
  logic           start_q, jump_q, wrap_q;
  logic           start_rise, jump_rise, wrap_rise, pause_rise;
  logic [HW-1:0]  hit_cnt, hit_nxt;
  logic [WW-1:0]  wrap_cnt, wrap_nxt;
  logic [1:0]     burst_left;

`ifdef GAME_SEQ_PAUSE_EN
  logic pause_q;
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) pause_q <= 1'b0;
    else        pause_q <= pause;
  end
  assign pause_rise = pause & ~pause_q;
`else
  assign pause_rise = 1'b0;
`endif

  // Tick is registered so it lands one cycle after the vsync fall is seen.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      tick    <= 1'b0;
      start_q <= 1'b0;
      jump_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      tick    <= vsync_q & ~vsync;
      start_q <= start;
      jump_q  <= jump;
      wrap_q  <= obs_wrap;
    end
  end

  assign start_rise = start & ~start_q;
  assign jump_rise  = jump & ~jump_q;
  assign wrap_rise  = obs_wrap & ~wrap_q;
  assign hit_nxt    = hit_cnt + HW'(1);
  assign wrap_nxt   = wrap_cnt + WW'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, GAME_OVER: if (start_rise) state_nxt = PLAY;
      PLAY: begin
        if (collide)         state_nxt = HIT;
        else if (pause_rise) state_nxt = PAUSE;
      end
      HIT:   if (tick && hit_cnt == HW'(HIT_FRAMES - 1)) state_nxt = GAME_OVER;
      PAUSE: if (pause_rise) state_nxt = PLAY;
      default: state_nxt = IDLE;
    endcase
  end

  // Collision wins over a simultaneous wrap, so the fatal wrap never scores.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      score     <= '0;
      level     <= '0;
      wrap_cnt  <= '0;
      hit_cnt   <= '0;
      obs_load  <= 1'b0;
      playing   <= 1'b0;
      flash     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      obs_load  <= 1'b0;
      playing   <= (state_nxt == PLAY);
      game_over <= (state_nxt == GAME_OVER);
      case (state)
        IDLE, GAME_OVER: begin
          if (start_rise) begin
            score    <= '0;
            level    <= '0;
            wrap_cnt <= '0;
            obs_load <= 1'b1;
          end
        end
        PLAY: begin
          if (collide) begin
            hit_cnt <= '0;
            flash   <= 1'b0;
          end else if (wrap_rise) begin
            obs_load <= 1'b1;
            if (score != SCORE_W'(SCORE_MAX)) score <= score + SCORE_W'(1);
            if (wrap_nxt == WW'(LEVEL_STEP)) begin
              wrap_cnt <= '0;
              if (level != 2'(MAX_LEVEL)) level <= level + 2'd1;
            end else begin
              wrap_cnt <= wrap_nxt;
            end
          end
        end
        HIT: begin
          if (tick) begin
            hit_cnt <= hit_nxt;
            flash   <= (state_nxt == GAME_OVER) ? 1'b0 : hit_nxt[3];
          end
        end
        default: ;
      endcase
    end
  end

  // A burst that has started runs to completion regardless of state.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      obs_step   <= 1'b0;
      burst_left <= '0;
    end else if (state == PLAY && tick) begin
      obs_step   <= 1'b1;
      burst_left <= level;
    end else if (burst_left != 2'd0) begin
      obs_step   <= 1'b1;
      burst_left <= burst_left - 2'd1;
    end else begin
      obs_step   <= 1'b0;
    end
  end

  game_jump_fsm #(
    .JUMP_FRAMES(JUMP_FRAMES)
  ) u_jump (
    .clk       (CLK_50M),
    .rst_n     (rst_n),
    .enable    (state == PLAY || state == PAUSE),
    .tick      (tick && state == PLAY),
    .jump_rise (jump_rise && state == PLAY),
    .ply_floor (ply_floor),
    .ply_apex  (ply_apex),
    .ply_step  (ply_step),
    .ply_up    (ply_up)
  );

endmodule
